// File: rtl/axin_dropfifo.sv
// axin_dropfifo: store-and-forward packet FIFO for an AXIN stream.
// Whole packets are buffered and released only once LAST arrives. Aborted or
// oversize packets are rewound out of the buffer, so the consumer only ever
// sees complete packets. The upstream side is never back-pressured.
module axin_dropfifo #(
  parameter int DW           = 64,
  parameter int WBITS        = $clog2(DW/8),
  parameter int LGFIFO       = 10,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DW-1:0]     S_DATA,
  input  logic [WBITS-1:0]  S_BYTES,
  input  logic              S_LAST,
  input  logic              S_ABORT,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DW-1:0]     M_DATA,
  output logic [WBITS-1:0]  M_BYTES,
  output logic              M_LAST,
  output logic              M_ABORT,
  output logic [LGFIFO:0]   o_fill,
  output logic [LGFIFO:0]   o_pkts,
  output logic [15:0]       o_drops
);

  localparam int MW = DW + WBITS + 1;

  localparam logic [LGFIFO:0] FIFO_DEPTH = {1'b1, {LGFIFO{1'b0}}};
  localparam logic [LGFIFO:0] PTR_ONE    = {{LGFIFO{1'b0}}, 1'b1};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MIDPKT = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  logic [MW-1:0]   mem [0:(1<<LGFIFO)-1];
  logic [MW-1:0]   ram_q;
  logic            ram_valid;

  logic [1:0]      wr_state, wr_next;
  logic [LGFIFO:0] wr_addr, wr_commit, rd_addr;
  logic [LGFIFO:0] occupancy;
  logic            full;

  logic            wr_en, do_commit, do_drop;
  logic            readable, out_load, rd_en, pkt_done;

  // The upstream side only stalls while reset is held.
  assign S_READY = !i_reset;
  assign M_ABORT = 1'b0;

  // Occupancy counts speculative beats too; a read this cycle does not help.
  assign occupancy = wr_addr - rd_addr;
  assign full      = (occupancy == FIFO_DEPTH);
  assign o_fill    = occupancy;

  // Write-side decode: which beats land, which commit, which trigger a rewind.
  always_comb begin
    wr_next   = wr_state;
    wr_en     = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    if (!i_reset) begin
      case (wr_state)
        IDLE, MIDPKT: begin
          if (S_ABORT) begin
            if (wr_state == MIDPKT) begin
              do_drop = 1'b1;
              wr_next = IDLE;
            end
          end else if (S_VALID) begin
            if (full) begin
              do_drop = 1'b1;
              wr_next = S_LAST ? IDLE : DROP;
            end else begin
              wr_en = 1'b1;
              if (S_LAST) begin
                do_commit = 1'b1;
                wr_next   = IDLE;
              end else begin
                wr_next = MIDPKT;
              end
            end
          end
        end
        DROP: begin
          if (S_ABORT || (S_VALID && S_LAST))
            wr_next = IDLE;
        end
        default: wr_next = IDLE;
      endcase
    end
  end

  // Write pointers, packet state and the saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_state  <= IDLE;
      wr_addr   <= '0;
      wr_commit <= '0;
      o_drops   <= '0;
    end else begin
      wr_state <= wr_next;
      if (do_drop) begin
        wr_addr <= wr_commit;
        if (o_drops != 16'hFFFF)
          o_drops <= o_drops + 16'd1;
      end else if (wr_en) begin
        wr_addr <= wr_addr + PTR_ONE;
        if (do_commit)
          wr_commit <= wr_addr + PTR_ONE;
      end
    end
  end

  // Packet storage write port.
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_addr[LGFIFO-1:0]] <= {S_LAST, S_BYTES, S_DATA};
  end

  // The RAM output acts as a pipeline stage ahead of the output register.
  assign readable = (wr_commit != rd_addr);
  assign out_load = !M_VALID || M_READY;
  assign rd_en    = readable && (!ram_valid || out_load);

  // Registered RAM read; holds its data while the output stage is stalled.
  always_ff @(posedge i_clk) begin
    if (rd_en)
      ram_q <= mem[rd_addr[LGFIFO-1:0]];
  end

  // Read pointer and valid flag for the RAM read stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_addr   <= '0;
      ram_valid <= 1'b0;
    end else if (rd_en) begin
      rd_addr   <= rd_addr + PTR_ONE;
      ram_valid <= 1'b1;
    end else if (out_load) begin
      ram_valid <= 1'b0;
    end
  end

  // Output valid follows the RAM stage whenever the consumer can take a beat.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      M_VALID <= 1'b0;
    else if (out_load)
      M_VALID <= ram_valid;
  end

  // Output payload; forced to zero when idle only in low-power builds.
  always_ff @(posedge i_clk) begin
    if (OPT_LOWPOWER && i_reset) begin
      M_LAST  <= 1'b0;
      M_BYTES <= '0;
      M_DATA  <= '0;
    end else if (out_load) begin
      if (ram_valid || !OPT_LOWPOWER) begin
        {M_LAST, M_BYTES, M_DATA} <= ram_q;
      end else begin
        M_LAST  <= 1'b0;
        M_BYTES <= '0;
        M_DATA  <= '0;
      end
    end
  end

  assign pkt_done = M_VALID && M_READY && M_LAST;

  // Committed-packet count: up on commit, down when a final beat leaves.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_pkts <= '0;
    else if (do_commit && !pkt_done)
      o_pkts <= o_pkts + PTR_ONE;
    else if (!do_commit && pkt_done)
      o_pkts <= o_pkts - PTR_ONE;
  end

endmodule

// File: tb/tb_axin_dropfifo.sv
// tb_axin_dropfifo: directed bench for axin_dropfifo with a beat scoreboard.
module tb_axin_dropfifo;

  localparam int DW     = 64;
  localparam int WBITS  = 3;
  localparam int LGFIFO = 4;

  logic              i_clk;
  logic              i_reset;
  logic              S_VALID;
  logic              S_READY;
  logic [DW-1:0]     S_DATA;
  logic [WBITS-1:0]  S_BYTES;
  logic              S_LAST;
  logic              S_ABORT;
  logic              M_VALID;
  logic              M_READY;
  logic [DW-1:0]     M_DATA;
  logic [WBITS-1:0]  M_BYTES;
  logic              M_LAST;
  logic              M_ABORT;
  logic [LGFIFO:0]   o_fill;
  logic [LGFIFO:0]   o_pkts;
  logic [15:0]       o_drops;

  typedef struct {
    logic [DW-1:0]    data;
    logic [WBITS-1:0] bytes;
    logic             last;
  } beat_t;

  beat_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit rand_ready  = 1'b0;

  bit               stall_prev = 1'b0;
  logic [DW-1:0]    prev_data;
  logic [WBITS-1:0] prev_bytes;
  logic             prev_last;

  axin_dropfifo #(
    .DW(DW), .WBITS(WBITS), .LGFIFO(LGFIFO), .OPT_LOWPOWER(1'b0)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .S_BYTES(S_BYTES), .S_LAST(S_LAST), .S_ABORT(S_ABORT),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .M_BYTES(M_BYTES), .M_LAST(M_LAST), .M_ABORT(M_ABORT),
    .o_fill(o_fill), .o_pkts(o_pkts), .o_drops(o_drops)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; inputs settle 1ns after the active edge.
  task automatic applyStimulus();
    if (rand_ready) M_READY = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    #1;
  endtask

  task automatic sendPacket(input int len, input logic [63:0] base,
                            input logic [WBITS-1:0] lastbytes,
                            input bit with_last, input bit keep);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      S_VALID = 1'b1;
      S_DATA  = base + 64'(i);
      S_LAST  = with_last && (i == len - 1);
      S_BYTES = (i == len - 1) ? lastbytes : '0;
      if (keep) begin
        b.data  = S_DATA;
        b.bytes = S_BYTES;
        b.last  = S_LAST;
        exp_q.push_back(b);
      end
      applyStimulus();
    end
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    S_BYTES = '0;
  endtask

  task automatic drainAll();
    bit drained = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0 && !M_VALID) begin
        drained = 1'b1;
        break;
      end
      applyStimulus();
    end
    checkOutput("drain", 64'(drained), 64'd1);
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    S_VALID = 1'b0;
    S_ABORT = 1'b0;
    S_LAST  = 1'b0;
    applyStimulus();
    checkOutput("rst_sready", 64'(S_READY), 64'd0);
    checkOutput("rst_mvalid", 64'(M_VALID), 64'd0);
    applyStimulus();
    i_reset = 1'b0;
    checkOutput("rst_fill", 64'(o_fill), 64'd0);
    checkOutput("rst_pkts", 64'(o_pkts), 64'd0);
    checkOutput("rst_drops", 64'(o_drops), 64'd0);
  endtask

  // Scoreboard monitor: compares accepted beats and checks stall stability.
  always @(negedge i_clk) begin
    if (i_reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", 64'(M_VALID), 64'd1);
        checkOutput("stall_data", M_DATA, prev_data);
        checkOutput("stall_bytes", 64'(M_BYTES), 64'(prev_bytes));
        checkOutput("stall_last", 64'(M_LAST), 64'(prev_last));
      end
      if (M_VALID && M_READY) begin
        checkOutput("unexpected_beat", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          checkOutput("m_data", M_DATA, e.data);
          checkOutput("m_bytes", 64'(M_BYTES), 64'(e.bytes));
          checkOutput("m_last", 64'(M_LAST), 64'(e.last));
        end
        checkOutput("m_abort", 64'(M_ABORT), 64'd0);
      end
      stall_prev = M_VALID && !M_READY;
      prev_data  = M_DATA;
      prev_bytes = M_BYTES;
      prev_last  = M_LAST;
    end
  end

  initial begin
    i_reset = 1'b1;
    S_VALID = 1'b0;
    S_DATA  = '0;
    S_BYTES = '0;
    S_LAST  = 1'b0;
    S_ABORT = 1'b0;
    M_READY = 1'b1;

    $display("[TB] 4-beat packet, latency and throughput");
    doReset();
    sendPacket(4, 64'd1, 3'd3, 1'b1, 1'b1);
    checkOutput("lat_n_valid", 64'(M_VALID), 64'd0);
    checkOutput("lat_n_pkts", 64'(o_pkts), 64'd1);
    applyStimulus();
    checkOutput("lat_n1_valid", 64'(M_VALID), 64'd0);
    applyStimulus();
    checkOutput("lat_n2_valid", 64'(M_VALID), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("burst_done_q", 64'(exp_q.size()), 64'd0);
    checkOutput("burst_done_valid", 64'(M_VALID), 64'd0);
    checkOutput("burst_pkts", 64'(o_pkts), 64'd0);
    checkOutput("burst_drops", 64'(o_drops), 64'd0);

    $display("[TB] abort mid-packet then 2-beat packet");
    doReset();
    sendPacket(3, 64'h100, 3'd0, 1'b0, 1'b0);
    S_ABORT = 1'b1;
    applyStimulus();
    S_ABORT = 1'b0;
    checkOutput("abort_drops", 64'(o_drops), 64'd1);
    checkOutput("abort_fill", 64'(o_fill), 64'd0);
    sendPacket(2, 64'h200, 3'd5, 1'b1, 1'b1);
    drainAll();
    checkOutput("abort_fill_end", 64'(o_fill), 64'd0);
    checkOutput("abort_drops_end", 64'(o_drops), 64'd1);

    $display("[TB] overflow drop then exact fill");
    doReset();
    M_READY = 1'b0;
    sendPacket(20, 64'h300, 3'd0, 1'b1, 1'b0);
    checkOutput("ovf_drops", 64'(o_drops), 64'd1);
    checkOutput("ovf_fill", 64'(o_fill), 64'd0);
    checkOutput("ovf_pkts", 64'(o_pkts), 64'd0);
    sendPacket(16, 64'h400, 3'd7, 1'b1, 1'b1);
    checkOutput("full_fill", 64'(o_fill), 64'd16);
    checkOutput("full_pkts", 64'(o_pkts), 64'd1);
    checkOutput("full_drops", 64'(o_drops), 64'd1);
    M_READY = 1'b1;
    drainAll();
    checkOutput("full_pkts_end", 64'(o_pkts), 64'd0);

    $display("[TB] random back-pressure over back-to-back packets");
    doReset();
    rand_ready = 1'b1;
    sendPacket(1, 64'h500, 3'd1, 1'b1, 1'b1);
    sendPacket(5, 64'h600, 3'd2, 1'b1, 1'b1);
    sendPacket(2, 64'h700, 3'd4, 1'b1, 1'b1);
    drainAll();
    rand_ready = 1'b0;
    M_READY = 1'b1;
    checkOutput("rand_pkts", 64'(o_pkts), 64'd0);
    checkOutput("rand_drops", 64'(o_drops), 64'd0);

    $display("[TB] reset mid-packet");
    doReset();
    sendPacket(2, 64'h800, 3'd0, 1'b0, 1'b0);
    doReset();
    sendPacket(1, 64'h900, 3'd6, 1'b1, 1'b1);
    drainAll();
    checkOutput("rstmid_drops", 64'(o_drops), 64'd0);
    checkOutput("rstmid_fill", 64'(o_fill), 64'd0);

    $display("[TB] abort with no packet open");
    doReset();
    S_ABORT = 1'b1;
    applyStimulus();
    checkOutput("idle_abort_drops", 64'(o_drops), 64'd0);
    checkOutput("idle_abort_fill", 64'(o_fill), 64'd0);
    S_VALID = 1'b1;
    S_LAST  = 1'b1;
    S_DATA  = 64'hDEAD;
    applyStimulus();
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    S_ABORT = 1'b0;
    checkOutput("idle_abort_beat_fill", 64'(o_fill), 64'd0);
    checkOutput("idle_abort_beat_pkts", 64'(o_pkts), 64'd0);
    checkOutput("idle_abort_beat_drops", 64'(o_drops), 64'd0);
    sendPacket(1, 64'hA00, 3'd0, 1'b1, 1'b1);
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
